// File: rtl/back_icon_exec_if.sv
// Interconnect executor bus bundle: instruction-queue head, source-EU read
// port and interconnect write port. Signal suffixes are from the executor's
// point of view; the executor uses the master modport, its environment
// (queue, register files, interconnect) uses the slave modport.
interface back_icon_exec_if #(
  parameter int EU_ID_WIDTH    = 3,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
);
  // instruction queue head
  logic                      instr_valid_i;
  logic [EU_ID_WIDTH-1:0]    instr_src_eu_i;
  logic [REG_ADDR_WIDTH-1:0] instr_src_reg_i;
  logic [EU_ID_WIDTH-1:0]    instr_dst_eu_i;
  logic [REG_ADDR_WIDTH-1:0] instr_dst_reg_i;
  logic                      instr_ready_o;
  // operand read port
  logic                      rd_req_o;
  logic [EU_ID_WIDTH-1:0]    rd_eu_o;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_o;
  logic                      rd_gnt_i;
  logic                      rd_data_valid_i;
  logic [DATA_WIDTH-1:0]     rd_data_i;
  // interconnect write port
  logic                      bus_valid_o;
  logic [EU_ID_WIDTH-1:0]    bus_dst_eu_o;
  logic [REG_ADDR_WIDTH-1:0] bus_dst_reg_o;
  logic [DATA_WIDTH-1:0]     bus_data_o;
  logic                      bus_ready_i;

  modport master (
    input  instr_valid_i, instr_src_eu_i, instr_src_reg_i, instr_dst_eu_i, instr_dst_reg_i,
    output instr_ready_o,
    output rd_req_o, rd_eu_o, rd_addr_o,
    input  rd_gnt_i, rd_data_valid_i, rd_data_i,
    output bus_valid_o, bus_dst_eu_o, bus_dst_reg_o, bus_data_o,
    input  bus_ready_i
  );

  modport slave (
    output instr_valid_i, instr_src_eu_i, instr_src_reg_i, instr_dst_eu_i, instr_dst_reg_i,
    input  instr_ready_o,
    input  rd_req_o, rd_eu_o, rd_addr_o,
    output rd_gnt_i, rd_data_valid_i, rd_data_i,
    input  bus_valid_o, bus_dst_eu_o, bus_dst_reg_o, bus_data_o,
    output bus_ready_i
  );
endinterface

// File: rtl/back_icon_exec.sv
// Interconnect instruction executor. Pops one register-move instruction at a
// time, reads the operand from the source EU and writes it over the
// interconnect to the destination EU register. One instruction in flight.
// Self-moves (same EU and register) are consumed as NOPs in a single cycle.
// All outputs come straight from flops; each transition sets the output
// values of the state it enters so the gating is exact in every state.
module back_icon_exec #(
  parameter int EU_ID_WIDTH    = 3,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  back_icon_exec_if.master     icon,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] xfer_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_SEND    = 2'd3
  } state_t;

  state_t                    state_q;
  logic                      instr_ready_q;
  logic                      busy_q;
  logic                      rd_req_q;
  logic [EU_ID_WIDTH-1:0]    rd_eu_q;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
  logic [EU_ID_WIDTH-1:0]    dst_eu_q;
  logic [REG_ADDR_WIDTH-1:0] dst_reg_q;
  logic                      bus_valid_q;
  logic [EU_ID_WIDTH-1:0]    bus_dst_eu_q;
  logic [REG_ADDR_WIDTH-1:0] bus_dst_reg_q;
  logic [DATA_WIDTH-1:0]     bus_data_q;
  logic [CNT_WIDTH-1:0]      xfer_count_q;
  logic [CNT_WIDTH-1:0]      xfer_count_d;

  logic pop;
  logic self_move;

  assign pop          = icon.instr_valid_i & instr_ready_q;
  assign self_move    = (icon.instr_src_eu_i == icon.instr_dst_eu_i) &&
                        (icon.instr_src_reg_i == icon.instr_dst_reg_i);
  // counter wraps naturally at 2^CNT_WIDTH
  assign xfer_count_d = xfer_count_q + CNT_WIDTH'(1);

  // Executor FSM with registered outputs; reset aborts any transfer in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      instr_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      rd_req_q      <= 1'b0;
      rd_eu_q       <= '0;
      rd_addr_q     <= '0;
      dst_eu_q      <= '0;
      dst_reg_q     <= '0;
      bus_valid_q   <= 1'b0;
      bus_dst_eu_q  <= '0;
      bus_dst_reg_q <= '0;
      bus_data_q    <= '0;
      xfer_count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // a popped self-move is simply dropped: stay ready, no activity
          if (pop && !self_move) begin
            state_q       <= ST_RD_REQ;
            instr_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            rd_req_q      <= 1'b1;
            rd_eu_q       <= icon.instr_src_eu_i;
            rd_addr_q     <= icon.instr_src_reg_i;
            dst_eu_q      <= icon.instr_dst_eu_i;
            dst_reg_q     <= icon.instr_dst_reg_i;
          end
        end
        ST_RD_REQ: begin
          if (icon.rd_gnt_i) begin
            state_q   <= ST_RD_WAIT;
            rd_req_q  <= 1'b0;
            rd_eu_q   <= '0;
            rd_addr_q <= '0;
          end
        end
        ST_RD_WAIT: begin
          // data valid is only meaningful here, i.e. from the cycle after grant
          if (icon.rd_data_valid_i) begin
            state_q       <= ST_SEND;
            bus_valid_q   <= 1'b1;
            bus_dst_eu_q  <= dst_eu_q;
            bus_dst_reg_q <= dst_reg_q;
            bus_data_q    <= icon.rd_data_i;
          end
        end
        ST_SEND: begin
          // bus fields stay put until the destination accepts
          if (icon.bus_ready_i) begin
            state_q       <= ST_IDLE;
            instr_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            bus_valid_q   <= 1'b0;
            bus_dst_eu_q  <= '0;
            bus_dst_reg_q <= '0;
            bus_data_q    <= '0;
            xfer_count_q  <= xfer_count_d;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          instr_ready_q <= 1'b1;
          busy_q        <= 1'b0;
          rd_req_q      <= 1'b0;
          rd_eu_q       <= '0;
          rd_addr_q     <= '0;
          bus_valid_q   <= 1'b0;
          bus_dst_eu_q  <= '0;
          bus_dst_reg_q <= '0;
          bus_data_q    <= '0;
        end
      endcase
    end
  end

  assign icon.instr_ready_o = instr_ready_q;
  assign icon.rd_req_o      = rd_req_q;
  assign icon.rd_eu_o       = rd_eu_q;
  assign icon.rd_addr_o     = rd_addr_q;
  assign icon.bus_valid_o   = bus_valid_q;
  assign icon.bus_dst_eu_o  = bus_dst_eu_q;
  assign icon.bus_dst_reg_o = bus_dst_reg_q;
  assign icon.bus_data_o    = bus_data_q;
  assign busy_o             = busy_q;
  assign xfer_count_o       = xfer_count_q;

endmodule

// File: tb/tb_back_icon_exec.sv
// Bench for back_icon_exec: directed latency/stall/NOP/reset cases followed
// by randomized traffic. A register-file model supplies read data; every
// non-NOP pop queues the transfer the bus must later carry, and a separate
// monitor compares each bus handshake and the transfer count.
`timescale 1ns/1ps
module tb_back_icon_exec;
  localparam int EW = 3;
  localparam int RW = 5;
  localparam int DW = 32;
  localparam int CW = 8;   // small counter so the wrap is reachable quickly

  typedef struct packed { logic [EW-1:0] se; logic [RW-1:0] sr; logic [EW-1:0] de; logic [RW-1:0] dr; } instr_t;
  typedef struct packed { logic [EW-1:0] de; logic [RW-1:0] dr; logic [DW-1:0] data; } xfer_t;
  typedef struct packed { logic [EW-1:0] eu; logic [RW-1:0] r; } rd_t;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic [CW-1:0] xfer_count;

  always #5 clk = ~clk;

  back_icon_exec_if #(.EU_ID_WIDTH(EW), .REG_ADDR_WIDTH(RW), .DATA_WIDTH(DW)) icon ();

  back_icon_exec #(.EU_ID_WIDTH(EW), .REG_ADDR_WIDTH(RW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .icon(icon), .busy_o(busy), .xfer_count_o(xfer_count)
  );

  logic [DW-1:0] regfile [8][32];
  instr_t dir_q[$];
  xfer_t  exp_q[$];
  rd_t    rd_q[$];
  int     pop_cyc[$];

  int tests = 0, fails = 0;
  int instr_pct = 0, nop_pct = 0, gnt_pct = 100, dv_pct = 100, rdy_pct = 100;
  int gnt_block = 0, rdy_block = 0;
  bit rand_en = 1'b0;
  int cyc = 0, pops = 0, xfers = 0, exp_count = 0;
  bit waiting = 1'b0;
  rd_t pend;
  bit have = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic instr_t gen_instr();
    instr_t t;
    t.se = EW'($urandom_range(7));
    t.sr = RW'($urandom_range(31));
    if ($urandom_range(99) < nop_pct) begin
      t.de = t.se; t.dr = t.sr;
    end else begin
      t.de = EW'($urandom_range(7));
      t.dr = RW'($urandom_range(31));
    end
    return t;
  endfunction

  // stimulus driver: instruction queue head, read-port responder, bus acceptor
  initial begin
    instr_t cur;
    int seen_pops;
    seen_pops = 0;
    cur = '0;
    icon.instr_valid_i = 1'b0; icon.instr_src_eu_i = '0; icon.instr_src_reg_i = '0;
    icon.instr_dst_eu_i = '0; icon.instr_dst_reg_i = '0;
    icon.rd_gnt_i = 1'b0; icon.rd_data_valid_i = 1'b0; icon.rd_data_i = '0; icon.bus_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (pops != seen_pops) begin have = 1'b0; seen_pops = pops; end
      if (!have) begin
        if (dir_q.size() > 0) begin cur = dir_q.pop_front(); have = 1'b1; end
        else if (rand_en && ($urandom_range(99) < instr_pct)) begin cur = gen_instr(); have = 1'b1; end
      end
      icon.instr_valid_i = have;
      if (have) begin
        icon.instr_src_eu_i = cur.se; icon.instr_src_reg_i = cur.sr;
        icon.instr_dst_eu_i = cur.de; icon.instr_dst_reg_i = cur.dr;
      end else begin
        icon.instr_src_eu_i = EW'($urandom); icon.instr_src_reg_i = RW'($urandom);
        icon.instr_dst_eu_i = EW'($urandom); icon.instr_dst_reg_i = RW'($urandom);
      end
      if (icon.rd_req_o) begin
        if (gnt_block > 0) begin icon.rd_gnt_i = 1'b0; gnt_block--; end
        else icon.rd_gnt_i = ($urandom_range(99) < gnt_pct);
      end else icon.rd_gnt_i = 1'b0;
      icon.rd_data_valid_i = ($urandom_range(99) < dv_pct);
      icon.rd_data_i = waiting ? regfile[pend.eu][pend.r] : $urandom;
      if (icon.bus_valid_o && rdy_block > 0) begin icon.bus_ready_i = 1'b0; rdy_block--; end
      else icon.bus_ready_i = ($urandom_range(99) < rdy_pct);
    end
  end

  // pop observer: records what each accepted instruction must produce
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete(); rd_q.delete(); waiting = 1'b0;
    end else begin
      if (waiting && icon.rd_data_valid_i) waiting = 1'b0;
      if (icon.rd_req_o && icon.rd_gnt_i) begin
        waiting = 1'b1; pend = '{eu: icon.rd_eu_o, r: icon.rd_addr_o};
      end
      if (icon.instr_valid_i && icon.instr_ready_o) begin
        pops++;
        pop_cyc.push_back(cyc);
        if (!(icon.instr_src_eu_i == icon.instr_dst_eu_i && icon.instr_src_reg_i == icon.instr_dst_reg_i)) begin
          rd_q.push_back('{eu: icon.instr_src_eu_i, r: icon.instr_src_reg_i});
          exp_q.push_back('{de: icon.instr_dst_eu_i, dr: icon.instr_dst_reg_i,
                            data: regfile[icon.instr_src_eu_i][icon.instr_src_reg_i]});
        end
      end
    end
  end

  // monitor: compares DUT activity against the queued expectations
  logic hold_v = 1'b0;
  logic [EW+RW+DW-1:0] held;
  always @(negedge clk) begin
    if (reset) begin
      exp_count = 0; xfers = 0; hold_v = 1'b0;
    end else begin
      chk("xfer_count", 64'(xfer_count), 64'(exp_count));
      chk("busy_vs_ready", 64'(busy), 64'(!icon.instr_ready_o));
      if (!icon.rd_req_o) chk("rd_gating", 64'({icon.rd_eu_o, icon.rd_addr_o}), 64'd0);
      if (!icon.bus_valid_o)
        chk("bus_gating", 64'({icon.bus_dst_eu_o, icon.bus_dst_reg_o, icon.bus_data_o}), 64'd0);
      if (hold_v)
        chk("bus_hold", 64'({icon.bus_valid_o, icon.bus_dst_eu_o, icon.bus_dst_reg_o, icon.bus_data_o}),
            64'({1'b1, held}));
      hold_v = icon.bus_valid_o && !icon.bus_ready_i;
      held = {icon.bus_dst_eu_o, icon.bus_dst_reg_o, icon.bus_data_o};
      if (icon.rd_req_o && icon.rd_gnt_i) begin
        chk("rd_expected", 64'(rd_q.size() > 0), 64'd1);
        if (rd_q.size() > 0) begin
          rd_t r;
          r = rd_q.pop_front();
          chk("rd_addr", 64'({icon.rd_eu_o, icon.rd_addr_o}), 64'(r));
        end
      end
      if (icon.bus_valid_o && icon.bus_ready_i) begin
        chk("bus_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          xfer_t e;
          e = exp_q.pop_front();
          chk("bus_dst", 64'({icon.bus_dst_eu_o, icon.bus_dst_reg_o}), 64'({e.de, e.dr}));
          chk("bus_data", 64'(icon.bus_data_o), 64'(e.data));
        end
        exp_count = (exp_count + 1) % (1 << CW);
        xfers++;
      end
    end
  end

  task automatic nclk();
    @(negedge clk); #1;
  endtask

  task automatic wait_pop(input string name);
    int n;
    n = 0;
    while (!(icon.instr_valid_i && icon.instr_ready_o) && n < 50) begin nclk(); n++; end
    chk({name, "_pop_timeout"}, 64'(n < 50), 64'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || have) && n < 400) begin nclk(); n++; end
    chk({name, "_idle_timeout"}, 64'(n < 400), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2; reset = 1'b1;
    nclk(); nclk();
    @(posedge clk); #2; reset = 1'b0;
    nclk();
  endtask

  // directed cases, then randomized traffic
  initial begin
    int n, rq, bv, rdy_bad, unstable, p0;
    logic [EW+RW+DW-1:0] first;
    for (int e = 0; e < 8; e++) for (int r = 0; r < 32; r++) regfile[e][r] = $urandom;
    regfile[2][5] = 32'hDEADBEEF;
    reset = 1'b1;
    repeat (3) nclk();
    chk("rst_ready", 64'(icon.instr_ready_o), 64'd1);
    chk("rst_outs", 64'({icon.rd_req_o, icon.bus_valid_o, busy, xfer_count}), 64'd0);
    @(posedge clk); #2; reset = 1'b0;
    nclk();
    chk("idle_ready", 64'(icon.instr_ready_o), 64'd1);

    // immediate grant/data/ready; data also offered in the grant cycle
    dir_q.push_back('{se: 3'd2, sr: 5'd5, de: 3'd4, dr: 5'd9});
    wait_pop("t2");
    nclk();
    chk("t2_rd_c1", 64'({icon.rd_req_o, icon.rd_eu_o, icon.rd_addr_o}), 64'({1'b1, 3'd2, 5'd5}));
    nclk();
    chk("t4_c2_no_early_send", 64'({icon.rd_req_o, icon.bus_valid_o}), 64'd0);
    nclk();
    chk("t2_bus_c3", 64'({icon.bus_valid_o, icon.bus_dst_eu_o, icon.bus_dst_reg_o, icon.bus_data_o}),
        64'({1'b1, 3'd4, 5'd9, 32'hDEADBEEF}));
    nclk();
    chk("t2_count_c4", 64'(xfer_count), 64'd1);
    chk("t2_idle_c4", 64'({busy, icon.instr_ready_o}), 64'b01);

    // grant stalled 5 cycles, bus stalled 3 cycles
    gnt_block = 5; rdy_block = 3;
    dir_q.push_back('{se: 3'd3, sr: 5'd7, de: 3'd6, dr: 5'd1});
    wait_pop("t3");
    nclk();
    rq = 0; bv = 0; rdy_bad = 0; unstable = 0; n = 0; first = '0;
    while (busy && n < 60) begin
      if (icon.rd_req_o) rq++;
      if (icon.bus_valid_o) begin
        if (bv == 0) first = {icon.bus_dst_eu_o, icon.bus_dst_reg_o, icon.bus_data_o};
        else if (first != {icon.bus_dst_eu_o, icon.bus_dst_reg_o, icon.bus_data_o}) unstable++;
        bv++;
      end
      if (icon.instr_ready_o) rdy_bad++;
      nclk(); n++;
    end
    chk("t3_rd_req_cycles", 64'(rq), 64'd6);
    chk("t3_bus_cycles", 64'(bv), 64'd4);
    chk("t3_bus_stable", 64'(unstable), 64'd0);
    chk("t3_ready_low", 64'(rdy_bad), 64'd0);
    chk("t3_bus_value", 64'(first), 64'({3'd6, 5'd1, regfile[3][7]}));

    // data valid only in the grant cycle must not be taken
    dir_q.push_back('{se: 3'd1, sr: 5'd2, de: 3'd5, dr: 5'd30});
    wait_pop("t4");
    nclk();
    chk("t4_grant_with_dv", 64'({icon.rd_req_o, icon.rd_gnt_i, icon.rd_data_valid_i}), 64'b111);
    dv_pct = 0;
    repeat (4) nclk();
    chk("t4_still_waiting", 64'({busy, icon.bus_valid_o}), 64'b10);
    dv_pct = 100;
    wait_idle("t4");
    chk("t4_drained", 64'(exp_q.size()), 64'd0);

    // three back-to-back self-moves
    p0 = pops;
    pop_cyc.delete();
    dir_q.push_back('{se: 3'd1, sr: 5'd3, de: 3'd1, dr: 5'd3});
    dir_q.push_back('{se: 3'd0, sr: 5'd0, de: 3'd0, dr: 5'd0});
    dir_q.push_back('{se: 3'd7, sr: 5'd31, de: 3'd7, dr: 5'd31});
    rq = 0;
    for (int i = 0; i < 8; i++) begin
      nclk();
      if (icon.rd_req_o || icon.bus_valid_o || busy) rq++;
    end
    chk("t5_pops", 64'(pops - p0), 64'd3);
    chk("t5_pop_span", 64'(pop_cyc.size() == 3 ? pop_cyc[2] - pop_cyc[0] : -1), 64'd2);
    chk("t5_no_activity", 64'(rq), 64'd0);
    chk("t5_count", 64'(xfer_count), 64'(exp_count));

    // reset in SEND with destination stalled
    rdy_block = 1000;
    dir_q.push_back('{se: 3'd4, sr: 5'd4, de: 3'd2, dr: 5'd8});
    wait_pop("t1");
    n = 0;
    while (!icon.bus_valid_o && n < 50) begin nclk(); n++; end
    chk("t1_reached_send", 64'(icon.bus_valid_o), 64'd1);
    @(posedge clk); #2; reset = 1'b1; #1;
    chk("t1_rst_busy_valid", 64'({busy, icon.bus_valid_o}), 64'd0);
    chk("t1_rst_count", 64'(xfer_count), 64'd0);
    chk("t1_rst_ready", 64'(icon.instr_ready_o), 64'd1);
    rdy_block = 0;
    nclk(); nclk();
    @(posedge clk); #2; reset = 1'b0;
    nclk();

    // randomized traffic in segments with varying handshake rates
    rand_en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      instr_pct = 30 + $urandom_range(70); nop_pct = $urandom_range(30);
      gnt_pct = 20 + $urandom_range(80); dv_pct = 20 + $urandom_range(80);
      rdy_pct = 20 + $urandom_range(80);
      repeat (400) nclk();
    end
    rand_en = 1'b0;
    wait_idle("rand");
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    // counter wrap at 2^CW
    do_reset();
    instr_pct = 100; nop_pct = 0; gnt_pct = 100; dv_pct = 100; rdy_pct = 100;
    rand_en = 1'b1;
    n = 0;
    while (xfers < (1 << CW) - 1 && n < 4000) begin nclk(); n++; end
    nclk();
    chk("t6_count_max", 64'(xfer_count), 64'((1 << CW) - 1));
    n = 0;
    while (xfers < (1 << CW) && n < 100) begin nclk(); n++; end
    nclk();
    chk("t6_count_wrap", 64'(xfer_count), 64'd0);
    rand_en = 1'b0;
    wait_idle("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end
endmodule
